qa_shim_rd_arbiter: RTL and testbench



---
 rtl/qa_shim_rd_arb_pkg.sv | 41 ++++
 rtl/qa_rr_arbiter.sv | 54 +++++
 rtl/qa_shim_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_qa_shim_rd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qa_shim_rd_arb_pkg.sv
// Shared types and tag-field helpers for the channel-0 read arbiter.
// Tags are laid out as {owner_bit, idx[IDX_W-1:0], mdata[MD_W-1:0]}, where the
// owner bit belongs to the upstream mux. The helpers accept tags up to TAG_MAX_W
// bits wide, zero-extended by the caller.
package qa_shim_rd_arb_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } t_RD_ARB_STATE;

  localparam int TAG_MAX_W = 32;

  // Width of the requester index field. It is never below 1, so the field stays legal.
  function automatic int calc_idx_w(input int n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  // Width of the client-owned mdata field.
  function automatic int calc_md_w(input int tag_w, input int n_req);
    return tag_w - 1 - calc_idx_w(n_req);
  endfunction

  // Requester index, which sits just below the upstream-owned MSB.
  function automatic logic [7:0] tag_idx(input logic [TAG_MAX_W-1:0] tag,
                                         input int tag_w, input int n_req);
    logic [TAG_MAX_W-1:0] mask;
    mask = (TAG_MAX_W'(1) << calc_idx_w(n_req)) - TAG_MAX_W'(1);
    return 8'((tag >> calc_md_w(tag_w, n_req)) & mask);
  endfunction

  // Client mdata, which sits in the low bits of the tag.
  function automatic logic [TAG_MAX_W-1:0] tag_mdata(input logic [TAG_MAX_W-1:0] tag,
                                                     input int tag_w, input int n_req);
    logic [TAG_MAX_W-1:0] mask;
    mask = (TAG_MAX_W'(1) << calc_md_w(tag_w, n_req)) - TAG_MAX_W'(1);
    return tag & mask;
  endfunction

endpackage

// File: rtl/qa_rr_arbiter.sv
// N-way rotating-priority arbiter. The search starts at ptr. A single grant is
// issued when en is high. After a grant, ptr moves to one past the winner.
// The arbiter is channel-agnostic, so the write path can reuse it.
module qa_rr_arbiter
  import qa_shim_rd_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = calc_idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  // Find the first requester at or after ptr, wrapping modulo N.
  always_comb begin
    logic [IDX_W-1:0] cand;
    int               j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      cand = IDX_W'(j);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found && en) grant[grant_idx] = 1'b1;
  end

  assign grant_any = found && en;

  // Move the priority pointer past the winner. The pointer holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/qa_shim_rd_arbiter.sv
// Round-robin scheduler for the CCI channel-0 read-request path. It tags each
// issued read with its requester index. It throttles issue on almost-full and on
// the outstanding limit, and it routes each response back to its owner by tag.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RUN     | grants allowed when the channel has room
//   DRAIN   | no new grants; responses still routed and counted
//   DRAINED | quiescent (zero outstanding); drained flag asserted
module qa_shim_rd_arbiter
  import qa_shim_rd_arb_pkg::*;
#(
  parameter  int N_REQ           = 4,
  parameter  int CCI_ADDR_WIDTH  = 32,
  parameter  int CCI_DATA_WIDTH  = 512,
  parameter  int CCI_TAG_WIDTH   = 13,
  parameter  int MAX_OUTSTANDING = 128,
  localparam int IDX_W           = calc_idx_w(N_REQ),
  localparam int MD_W            = calc_md_w(CCI_TAG_WIDTH, N_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*CCI_ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*MD_W-1:0]       req_mdata,
  output logic [N_REQ-1:0]            req_grant,
  output logic [CCI_ADDR_WIDTH-1:0]   tx_rd_addr,
  output logic [CCI_TAG_WIDTH-1:0]    tx_rd_tag,
  output logic                        tx_rd_valid,
  input  logic                        tx_almfull,
  input  logic                        rx_rd_valid,
  input  logic [CCI_TAG_WIDTH-1:0]    rx_rd_tag,
  input  logic [CCI_DATA_WIDTH-1:0]   rx_rd_data,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [MD_W-1:0]             rsp_mdata,
  output logic [CCI_DATA_WIDTH-1:0]   rsp_data,
  input  logic                        drain_req,
  output logic                        drained,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        err_underflow
);

  t_RD_ARB_STATE    state, state_nxt;
  logic             en;
  logic             accept;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rx_idx;
  logic [MD_W-1:0]  rx_mdata;
  logic             rx_idx_ok;
  logic             rx_underflow;

  // The almost-full input is sampled in the same cycle as the grant. Upstream
  // absorbs the one registered request that can still follow it.
  assign en = (state == RUN) && !tx_almfull && (outstanding < CNT_W'(MAX_OUTSTANDING));

  qa_rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req_valid),
    .grant     (req_grant),
    .grant_idx (grant_idx),
    .grant_any (accept)
  );

  assign rx_idx       = IDX_W'(tag_idx(TAG_MAX_W'(rx_rd_tag), CCI_TAG_WIDTH, N_REQ));
  assign rx_mdata     = MD_W'(tag_mdata(TAG_MAX_W'(rx_rd_tag), CCI_TAG_WIDTH, N_REQ));
  assign rx_idx_ok    = int'(rx_idx) < N_REQ;
  assign rx_underflow = rx_rd_valid && (outstanding == '0);

  // Drain sequencing. DRAIN falls back to RUN if the request is withdrawn before the channel empties.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)              state_nxt = RUN;
        else if (outstanding == '0)  state_nxt = DRAINED;
      end
      DRAINED: if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register and registered drained flag. The flag lags entry into DRAINED by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      state   <= state_nxt;
      drained <= (state == DRAINED);
    end
  end

  // In-flight counter. A response at zero is an error: the count holds at zero
  // and takes only any same-cycle issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else if (rx_underflow) begin
      outstanding <= accept ? CNT_W'(1) : '0;
    end else if (accept && !rx_rd_valid) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && rx_rd_valid) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // Sticky error flag. It sets on an underflow or on a response whose index has no owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else if (rx_underflow || (rx_rd_valid && !rx_idx_ok)) begin
      err_underflow <= 1'b1;
    end
  end

  // Register the winning request onto channel 0. The MSB of the tag belongs to the upstream mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd_valid <= 1'b0;
      tx_rd_addr  <= '0;
      tx_rd_tag   <= '0;
    end else begin
      tx_rd_valid <= accept;
      if (accept) begin
        tx_rd_addr <= req_addr[grant_idx*CCI_ADDR_WIDTH +: CCI_ADDR_WIDTH];
        tx_rd_tag  <= {1'b0, grant_idx, req_mdata[grant_idx*MD_W +: MD_W]};
      end
    end
  end

  // Return each response to the client named in its tag. A response with an unknown index is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_mdata <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (rx_rd_valid && rx_idx_ok) ? (N_REQ'(1) << rx_idx) : '0;
      if (rx_rd_valid) begin
        rsp_mdata <= rx_mdata;
        rsp_data  <= rx_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_qa_shim_rd_arbiter.sv
// Scoreboard bench for qa_shim_rd_arbiter with 4 clients and a limit of 4 outstanding reads.
module tb_qa_shim_rd_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int TW   = 13;
  localparam int MAXO = 4;
  localparam int IW   = 2;
  localparam int MW   = TW - 1 - IW;
  localparam int CW   = $clog2(MAXO + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*MW-1:0]   req_mdata;
  logic [N-1:0]      req_grant;
  logic [AW-1:0]     tx_rd_addr;
  logic [TW-1:0]     tx_rd_tag;
  logic              tx_rd_valid;
  logic              tx_almfull;
  logic              rx_rd_valid;
  logic [TW-1:0]     rx_rd_tag;
  logic [DW-1:0]     rx_rd_data;
  logic [N-1:0]      rsp_valid;
  logic [MW-1:0]     rsp_mdata;
  logic [DW-1:0]     rsp_data;
  logic              drain_req;
  logic              drained;
  logic [CW-1:0]     outstanding;
  logic              err_underflow;

  qa_shim_rd_arbiter #(
    .N_REQ           (N),
    .CCI_ADDR_WIDTH  (AW),
    .CCI_DATA_WIDTH  (DW),
    .CCI_TAG_WIDTH   (TW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_mdata     (req_mdata),
    .req_grant     (req_grant),
    .tx_rd_addr    (tx_rd_addr),
    .tx_rd_tag     (tx_rd_tag),
    .tx_rd_valid   (tx_rd_valid),
    .tx_almfull    (tx_almfull),
    .rx_rd_valid   (rx_rd_valid),
    .rx_rd_tag     (rx_rd_tag),
    .rx_rd_data    (rx_rd_data),
    .rsp_valid     (rsp_valid),
    .rsp_mdata     (rsp_mdata),
    .rsp_data      (rsp_data),
    .drain_req     (drain_req),
    .drained       (drained),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } tx_exp_t;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [MW-1:0] md;
    logic [DW-1:0] data;
  } rsp_exp_t;

  tx_exp_t  tx_q[$];
  rsp_exp_t rsp_q[$];

  int   m_ptr, m_out, m_state;
  logic m_err, m_drained;

  // Reference model and scoreboard. This block samples at the negedge, when the
  // inputs for the next posedge are already stable.
  always @(negedge clk) begin
    tx_exp_t      te;
    rsp_exp_t     re;
    logic         en;
    logic         acc;
    logic [N-1:0] eg;
    int           gi;
    int           j;
    if (reset) begin
      m_ptr = 0; m_out = 0; m_state = 0; m_err = 1'b0; m_drained = 1'b0;
      tx_q.delete();
      rsp_q.delete();
    end else begin
      if (tx_rd_valid) begin
        if (tx_q.size() == 0) check_eq("tx_spurious", tx_rd_valid, 0);
        else begin
          te = tx_q.pop_front();
          check_eq("tx_addr", tx_rd_addr, te.addr);
          check_eq("tx_tag", tx_rd_tag, te.tag);
        end
      end else if (tx_q.size() != 0) begin
        check_eq("tx_missing", tx_rd_valid, 1);
        tx_q.delete();
      end
      if (rsp_q.size() != 0) begin
        re = rsp_q.pop_front();
        check_eq("rsp_valid", rsp_valid, re.vld);
        check_eq("rsp_mdata", rsp_mdata, re.md);
        check_eq("rsp_data", rsp_data, re.data);
      end else begin
        check_eq("rsp_idle", rsp_valid, 0);
      end
      check_eq("outstanding", outstanding, m_out);
      check_eq("drained", drained, m_drained);
      check_eq("err_underflow", err_underflow, m_err);

      en = (m_state == 0) && !tx_almfull && (m_out < MAXO);
      gi = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (gi < 0 && req_valid[j]) gi = j;
      end
      eg = '0;
      if (gi >= 0 && en) eg[gi] = 1'b1;
      check_eq("req_grant", req_grant, eg);
      acc = (eg != '0);
      if (acc) begin
        te.addr = req_addr[gi*AW +: AW];
        te.tag  = {1'b0, IW'(gi), req_mdata[gi*MW +: MW]};
        tx_q.push_back(te);
        m_ptr = (gi + 1) % N;
      end
      if (rx_rd_valid) begin
        re.vld  = N'(1) << rx_rd_tag[TW-2 -: IW];
        re.md   = rx_rd_tag[MW-1:0];
        re.data = rx_rd_data;
        rsp_q.push_back(re);
      end

      m_drained = (m_state == 2);
      case (m_state)
        0: if (drain_req) m_state = 1;
        1: if (!drain_req) m_state = 0; else if (m_out == 0) m_state = 2;
        2: if (!drain_req) m_state = 0;
        default: m_state = 0;
      endcase
      if (rx_rd_valid && m_out == 0) begin
        m_err = 1'b1;
        m_out = acc ? 1 : 0;
      end else begin
        m_out = m_out + (acc ? 1 : 0) - (rx_rd_valid ? 1 : 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rsp(input logic [IW-1:0] idx, input logic [MW-1:0] md, input logic [DW-1:0] data);
    step();
    rx_rd_valid = 1'b1;
    rx_rd_tag   = {1'b0, idx, md};
    rx_rd_data  = data;
    step();
    rx_rd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_mdata = '0; tx_almfull = 1'b0;
    rx_rd_valid = 1'b0; rx_rd_tag = '0; rx_rd_data = '0; drain_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 32'h1000_0000 + i * 32'h40;
      req_mdata[i*MW +: MW] = MW'(10'h200 + i * 7);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_tx_valid", tx_rd_valid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_err", err_underflow, 0);
    check_eq("rst_drained", drained, 0);

    // All clients request: grants go 0,1,2,3 and then stop at the limit.
    step(); req_valid = 4'hF;
    repeat (5) step();
    @(negedge clk);
    check_eq("limit_outstanding", outstanding, 4);
    check_eq("limit_no_grant", req_grant, 0);
    send_rsp(2'd1, 10'h3AB, 64'hAAAA_0000_0000_0001);
    step(); req_valid = '0;
    @(negedge clk);
    check_eq("refill_outstanding", outstanding, 4);
    check_eq("refill_tx_valid", tx_rd_valid, 1);
    check_eq("refill_tx_tag", tx_rd_tag, {1'b0, 2'd0, 10'h200});

    // Return all four reads, including idx 2 / mdata 0x1F.
    send_rsp(2'd0, 10'h011, 64'h0123_4567_89AB_CDEF);
    send_rsp(2'd2, 10'h01F, 64'hDEAD_BEEF_0000_0002);
    @(negedge clk);
    check_eq("route_rsp_valid", rsp_valid, 4'b0100);
    check_eq("route_rsp_mdata", rsp_mdata, 10'h01F);
    send_rsp(2'd3, 10'h2F0, 64'h3333_3333_3333_3333);
    send_rsp(2'd1, 10'h0C3, 64'h1111_0000_1111_0000);
    step();
    @(negedge clk);
    check_eq("empty_outstanding", outstanding, 0);
    check_eq("empty_err", err_underflow, 0);

    // A response arriving at zero outstanding sets the sticky error.
    send_rsp(2'd2, 10'h155, 64'h5555_5555_5555_5555);
    step();
    @(negedge clk);
    check_eq("underflow_err", err_underflow, 1);
    check_eq("underflow_outstanding", outstanding, 0);

    // Almost-full blocks grants for 10 cycles; the pointer stays at 1.
    step(); tx_almfull = 1'b1; req_valid = 4'b1010;
    repeat (10) step();
    tx_almfull = 1'b0;
    @(negedge clk);
    check_eq("almfull_resume_grant", req_grant, 4'b0010);
    step(); step();
    step(); req_valid = '0; drain_req = 1'b1;
    step(); req_valid = 4'b1010;
    repeat (3) step();
    @(negedge clk);
    check_eq("drain_outstanding", outstanding, 3);
    check_eq("drain_no_grant", req_grant, 0);
    check_eq("drain_no_tx", tx_rd_valid, 0);
    send_rsp(2'd1, 10'h207, 64'h0000_0000_0000_0A01);
    send_rsp(2'd3, 10'h215, 64'h0000_0000_0000_0A03);
    send_rsp(2'd1, 10'h207, 64'h0000_0000_0000_0A11);
    step(); step();
    @(negedge clk);
    check_eq("drained_flag", drained, 1);
    step(); drain_req = 1'b0;
    step();
    @(negedge clk);
    check_eq("run_resume_grant", req_grant, 4'b1000);

    // A response in the same cycle as an issue leaves the count unchanged.
    step();
    rx_rd_valid = 1'b1; rx_rd_tag = {1'b0, 2'd3, 10'h215}; rx_rd_data = 64'hC0FF_EE00_0000_0003;
    step(); rx_rd_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    check_eq("simul_outstanding", outstanding, 1);
    check_eq("simul_tx_valid", tx_rd_valid, 1);
    step();
    @(negedge clk);
    check_eq("err_sticky", err_underflow, 1);

    // Reset clears the sticky error and the counter.
    step(); reset = 1'b1;
    step(); step(); reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_err", err_underflow, 0);
    check_eq("post_rst_outstanding", outstanding, 0);
    check_eq("post_rst_drained", drained, 0);
    repeat (3) step();
    @(negedge clk);
    check_eq("tx_q_empty", tx_q.size(), 0);
    check_eq("rsp_q_empty", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
